// File: rtl/act_collector.sv
`default_nettype none
// ============================================================================
// act_collector : requantizes mac_engine results (shift, ReLU, saturate) and
//                 packs one layer into an invec_bus-compatible vector.
// Revision      : 1.0
// ============================================================================
module act_collector #(
    parameter int DATA_W    = 16,
    parameter int N_IN      = 10,
    parameter int N_HIDDEN  = 8,
    parameter int ACC_W     = 2*DATA_W + $clog2((N_IN > 2) ? N_IN : 2),
    parameter int SAT_CNT_W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ACC_W-1:0]               in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [$clog2(ACC_W)-1:0]       shift_amt,
    input  logic                           relu_en,
    input  logic                           flush,
    output logic [N_IN*DATA_W-1:0]         vec_bus,
    output logic                           vec_valid,
    input  logic                           vec_ack,
    output logic [$clog2(N_HIDDEN+1)-1:0]  count,
    output logic [SAT_CNT_W-1:0]           sat_cnt
);

    localparam int CNT_W = $clog2(N_HIDDEN+1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                    state;
    logic                      accept;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [ACC_W-1:0]   rectified;
    logic [DATA_W-1:0]         quant;
    logic                      clamp;

    assign in_ready = rst_n && (state == COLLECT) && !flush;
    assign accept   = in_valid && in_ready;

    // Arithmetic shift floors toward -inf; a ReLU-zeroed value can never clamp.
    always_comb begin
        shifted   = $signed(in_data) >>> shift_amt;
        rectified = (relu_en && shifted[ACC_W-1]) ? '0 : shifted;
        quant     = rectified[DATA_W-1:0];
        clamp     = 1'b0;
        if (rectified > SAT_MAX) begin
            quant = {1'b0, {(DATA_W-1){1'b1}}};
            clamp = 1'b1;
        end else if (rectified < SAT_MIN) begin
            quant = {1'b1, {(DATA_W-1){1'b0}}};
            clamp = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state     <= COLLECT;
            count     <= '0;
            sat_cnt   <= '0;
            vec_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        count <= count + CNT_W'(1);
                        if (clamp && (sat_cnt != {SAT_CNT_W{1'b1}}))
                            sat_cnt <= sat_cnt + SAT_CNT_W'(1);
                        if (count == CNT_W'(N_HIDDEN-1)) begin
                            state     <= FULL;
                            vec_valid <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (vec_ack) begin
                        state     <= COLLECT;
                        count     <= '0;
                        sat_cnt   <= '0;
                        vec_valid <= 1'b0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // Lanes keep their contents across an ack; only flush/reset zero them.
    generate
        for (genvar k = 0; k < N_HIDDEN; k++) begin : g_lane
            logic [DATA_W-1:0] lane_q;
            always_ff @(posedge clk) begin
                if (!rst_n || flush)
                    lane_q <= '0;
                else if (accept && (count == CNT_W'(k)))
                    lane_q <= quant;
            end
            assign vec_bus[k*DATA_W +: DATA_W] = lane_q;
        end
        if (N_IN > N_HIDDEN) begin : g_pad
            assign vec_bus[N_IN*DATA_W-1 : N_HIDDEN*DATA_W] = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_act_collector.sv
`default_nettype none
// ============================================================================
// tb_act_collector : directed + randomized checks against a requantize model.
// Revision         : 1.0
// ============================================================================
module tb_act_collector;

    localparam int DATA_W    = 16;
    localparam int N_IN      = 10;
    localparam int N_HIDDEN  = 8;
    localparam int ACC_W     = 2*DATA_W + $clog2(N_IN);
    localparam int SAT_CNT_W = 8;
    localparam int SH_W      = $clog2(ACC_W);
    localparam int CNT_W     = $clog2(N_HIDDEN+1);
    localparam int BUS_W     = N_IN*DATA_W;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [ACC_W-1:0]      in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [SH_W-1:0]       shift_amt;
    logic                  relu_en;
    logic                  flush;
    logic [BUS_W-1:0]      vec_bus;
    logic                  vec_valid;
    logic                  vec_ack;
    logic [CNT_W-1:0]      count;
    logic [SAT_CNT_W-1:0]  sat_cnt;

    act_collector #(
        .DATA_W(DATA_W), .N_IN(N_IN), .N_HIDDEN(N_HIDDEN),
        .ACC_W(ACC_W), .SAT_CNT_W(SAT_CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .shift_amt(shift_amt), .relu_en(relu_en),
        .flush(flush), .vec_bus(vec_bus), .vec_valid(vec_valid),
        .vec_ack(vec_ack), .count(count), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a layer is a list of lane values plus a "full" flag.
    bit                m_full;
    int                m_cnt;
    int                m_sat;
    logic [DATA_W-1:0] m_lane [N_IN];
    bit                stalled_prev;
    logic [ACC_W-1:0]  data_prev;
    logic [BUS_W-1:0]  saved_bus;

    task automatic chk(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void requant(input logic [ACC_W-1:0] d, input int sh, input bit relu,
                                    output logic [DATA_W-1:0] q, output bit clamped);
        longint v;
        longint mx;
        longint mn;
        mx = (longint'(1) << (DATA_W-1)) - 1;
        mn = -mx - 1;
        v  = $signed({{(64-ACC_W){d[ACC_W-1]}}, d});
        v  = v >>> sh;
        if (relu && v < 0) v = 0;
        clamped = 1'b0;
        if (v > mx) begin v = mx; clamped = 1'b1; end
        else if (v < mn) begin v = mn; clamped = 1'b1; end
        q = v[DATA_W-1:0];
    endfunction

    function automatic logic [BUS_W-1:0] bus_exp();
        logic [BUS_W-1:0] b;
        for (int k = 0; k < N_IN; k++) b[k*DATA_W +: DATA_W] = m_lane[k];
        return b;
    endfunction

    function automatic logic [ACC_W-1:0] rand_acc();
        logic [63:0]             r;
        logic signed [ACC_W-1:0] s;
        r = {$urandom, $urandom};
        s = r[ACC_W-1:0];
        s = s >>> $urandom_range(0, 30);
        return s;
    endfunction

    task automatic model_clear(input bit lanes_too);
        m_full = 1'b0;
        m_cnt  = 0;
        m_sat  = 0;
        if (lanes_too) for (int k = 0; k < N_IN; k++) m_lane[k] = '0;
    endtask

    task automatic tick();
        bit                rdy;
        logic [DATA_W-1:0] q;
        bit                c;
        #1;
        rdy = rst_n && !m_full && !flush;
        chk("in_ready", BUS_W'(in_ready), BUS_W'(rdy));
        if (stalled_prev && in_valid) chk("producer_hold", BUS_W'(in_data), BUS_W'(data_prev));
        stalled_prev = in_valid && rst_n && !flush && m_full;
        data_prev    = in_data;
        @(posedge clk);
        if (!rst_n || flush) begin
            model_clear(1'b1);
        end else if (!m_full) begin
            if (in_valid) begin
                requant(in_data, int'(shift_amt), relu_en, q, c);
                m_lane[m_cnt] = q;
                if (c && m_sat < (1 << SAT_CNT_W) - 1) m_sat++;
                m_cnt++;
                if (m_cnt == N_HIDDEN) m_full = 1'b1;
            end
        end else if (vec_ack) begin
            model_clear(1'b0);
        end
        #1;
        chk("count",     BUS_W'(count),     BUS_W'(m_cnt));
        chk("sat_cnt",   BUS_W'(sat_cnt),   BUS_W'(m_sat));
        chk("vec_valid", BUS_W'(vec_valid), BUS_W'(m_full));
        chk("vec_bus",   vec_bus,           bus_exp());
    endtask

    task automatic send(input logic [ACC_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic ack();
        in_valid = 1'b0;
        vec_ack  = 1'b1;
        tick();
        vec_ack  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; shift_amt = '0;
        relu_en = 1'b0; flush = 1'b0; vec_ack = 1'b0;
        stalled_prev = 1'b0; data_prev = '0;
        model_clear(1'b1);

        // Reset
        repeat (3) tick();
        chk("rst_in_ready", BUS_W'(in_ready), BUS_W'(0));
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", BUS_W'(in_ready), BUS_W'(1));

        // Basic pack
        for (int i = 1; i <= N_HIDDEN; i++) send(ACC_W'(i));
        chk("pack_valid", BUS_W'(vec_valid), BUS_W'(1));
        for (int k = 0; k < N_HIDDEN; k++) chk("pack_lane", BUS_W'(vec_bus[k*DATA_W +: DATA_W]), BUS_W'(k+1));
        chk("pack_pad", BUS_W'(vec_bus[BUS_W-1 -: 2*DATA_W]), BUS_W'(0));
        chk("pack_sat", BUS_W'(sat_cnt), BUS_W'(0));
        idle(1);
        ack();

        // Shift, rounding and ReLU
        shift_amt = SH_W'(2);
        send(ACC_W'(1000));
        send(ACC_W'(-7));
        relu_en = 1'b1;
        send(ACC_W'(-50));
        idle(1);
        chk("shift_lane0", BUS_W'(vec_bus[0 +: DATA_W]),        BUS_W'(250));
        chk("shift_lane1", BUS_W'(vec_bus[DATA_W +: DATA_W]),   BUS_W'(16'hFFFE));
        chk("relu_lane2",  BUS_W'(vec_bus[2*DATA_W +: DATA_W]), BUS_W'(0));
        chk("shift_sat",   BUS_W'(sat_cnt), BUS_W'(0));
        flush = 1'b1; tick(); flush = 1'b0;
        relu_en = 1'b0; shift_amt = '0;

        // Saturation
        send(ACC_W'(100000));
        send(ACC_W'(-100000));
        send(ACC_W'(32767));
        send(36'h7_FFFF_FFFF);
        repeat (4) send('0);
        idle(1);
        chk("sat_lane0", BUS_W'(vec_bus[0 +: DATA_W]),        BUS_W'(16'h7FFF));
        chk("sat_lane1", BUS_W'(vec_bus[DATA_W +: DATA_W]),   BUS_W'(16'h8000));
        chk("sat_lane2", BUS_W'(vec_bus[2*DATA_W +: DATA_W]), BUS_W'(16'h7FFF));
        chk("sat_lane3", BUS_W'(vec_bus[3*DATA_W +: DATA_W]), BUS_W'(16'h7FFF));
        chk("sat_count", BUS_W'(sat_cnt), BUS_W'(3));
        ack();

        // Backpressure
        for (int i = 0; i < N_HIDDEN; i++) send(rand_acc());
        saved_bus = vec_bus;
        in_valid = 1'b1; in_data = ACC_W'(55);
        repeat (5) begin
            tick();
            chk("stall_bus", vec_bus, saved_bus);
        end
        vec_ack = 1'b1; tick(); vec_ack = 1'b0;
        tick();
        chk("bp_count", BUS_W'(count), BUS_W'(1));
        chk("bp_lane0", BUS_W'(vec_bus[0 +: DATA_W]), BUS_W'(55));
        idle(1);

        // Flush and reset mid-layer
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_acc());
        flush = 1'b1; in_valid = 1'b1; in_data = rand_acc();
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", BUS_W'(count), BUS_W'(0));
        chk("flush_bus",   vec_bus, BUS_W'(0));
        for (int i = 0; i < 5; i++) send(rand_acc());
        rst_n = 1'b0; tick(); rst_n = 1'b1; in_valid = 1'b0;
        chk("rst_count", BUS_W'(count), BUS_W'(0));
        chk("rst_bus",   vec_bus, BUS_W'(0));
        // Flush beats a coincident ack while full
        for (int i = 0; i < N_HIDDEN; i++) send(rand_acc());
        in_valid = 1'b0; flush = 1'b1; vec_ack = 1'b1;
        tick();
        flush = 1'b0; vec_ack = 1'b0;
        chk("flush_full_valid", BUS_W'(vec_valid), BUS_W'(0));

        // Chained random layers with bubbles and stray acks
        for (int layer = 0; layer < 3; layer++) begin
            int guard;
            shift_amt = SH_W'($urandom_range(0, 20));
            relu_en   = 1'($urandom_range(0, 1));
            guard     = 0;
            while (!m_full && guard < 200) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = rand_acc();
                vec_ack  = ($urandom_range(0, 7) == 0);
                tick();
                guard++;
            end
            vec_ack = 1'b0;
            chk("layer_complete", BUS_W'(m_full), BUS_W'(1));
            idle($urandom_range(0, 3));
            chk("layer_bus", vec_bus, bus_exp());
            ack();
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/act_collector.md
# act_collector

Output-side consumer for `mac_engine`'s result stream.
- Accepts signed accumulator results one neuron at a time over a valid/ready handshake.
- Requantizes each result to `DATA_W` by arithmetic shift, optional ReLU and saturation.
- Packs the `N_HIDDEN` results of a layer into a vector bus laid out exactly like `mac_engine`'s `invec_bus`, so one layer's outputs feed the next layer.
- Sits between `mac_engine.out_*` and the input-vector bus of the following compute pass.

## Interface
- `DATA_W`, 16, activation/weight width.
- `N_IN`, 10, lanes in the output vector bus. Must satisfy `N_IN >= N_HIDDEN`.
- `N_HIDDEN`, 8, results per layer.
- `ACC_W`, `2*DATA_W + $clog2(max(N_IN,2))`, incoming accumulator width.
- `SAT_CNT_W`, 8, saturation event counter width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low; clock `clk`.
- `in_data`  in  `ACC_W`  signed accumulator result.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  collector can accept a result.
- `shift_amt`  in  `$clog2(ACC_W)`  right-shift applied before saturation.
- `relu_en`  in  1  clamp negative requantized values to 0.
- `flush`  in  1  synchronous abort of the current collection.
- `vec_bus`  out  `N_IN*DATA_W`  packed vector; lane `k` occupies bits `[k*DATA_W +: DATA_W]`.
- `vec_valid`  out  1  all `N_HIDDEN` lanes are written.
- `vec_ack`  in  1  consumer has finished with `vec_bus`.
- `count`  out  `$clog2(N_HIDDEN+1)`  lanes written so far.
- `sat_cnt`  out  `SAT_CNT_W`  number of saturation events in the current vector.

## Operation
- Two states: COLLECT and FULL.
- `in_ready = rst_n && (state==COLLECT) && !flush`. This is the only combinational output.
- Accept happens when `in_valid && in_ready`.
- Requantize on accept:
  - `s = in_data >>> shift_amt`, arithmetic shift, so rounding is toward negative infinity.
  - If `relu_en` and `s < 0`, then `s = 0`.
  - Clamp `s` to `[-2^(DATA_W-1), 2^(DATA_W-1)-1]`.
  - A clamp increments `sat_cnt`; the counter holds at its all-ones value. A ReLU clamp is not counted.
- The result is written to lane `count`, then `count` increments.
- `shift_amt` and `relu_en` are sampled at each accept. The driver holds them constant for a whole layer.
- COLLECT to FULL: on the accept that makes `count == N_HIDDEN`. In FULL, `vec_valid=1` and `in_ready=0`.
- FULL to COLLECT: on `vec_ack`.
  - `count` and `sat_cnt` clear; `vec_valid` drops.
  - `vec_bus` contents are retained until they are overwritten lane by lane.
- `vec_ack` while in COLLECT is ignored.
- Lanes `N_HIDDEN..N_IN-1` are always zero.
- `flush`, in either state: next cycle the block is in COLLECT with `count=0`, `sat_cnt=0`, `vec_bus=0`, `vec_valid=0`.
  - `flush` overrides a coincident `in_valid`; the sample is not accepted.
  - `flush` overrides a coincident `vec_ack`.
- `vec_bus` is stable for the entire time `vec_valid=1`.

## Timing
- Reset values: state COLLECT, `count=0`, `sat_cnt=0`, `vec_bus=0`, `vec_valid=0`. `in_ready=0` while `rst_n=0`, and 1 on the first cycle after release.
- Throughput: one accept per cycle in COLLECT, with no bubbles.
- Accept at edge `t`: the lane value and `count` are visible after `t`.
- Final accept at edge `t`: `vec_valid=1` and `in_ready=0` from `t` onward, so there is no gap cycle.
- `vec_ack` sampled at edge `t`: `vec_valid=0` and `in_ready=1` after `t`, so a new accept is possible at edge `t+1`.
- Reset asserted mid-collection: all state returns to reset values at the next edge, and partial lanes are discarded.
- Producer rule: `in_data` is held stable while `in_valid && !in_ready`. The bench asserts this.

## Test plan
- Basic pack: `DATA_W=16`, `shift_amt=0`, `relu_en=0`, send results 1..8 back-to-back. Required: 8 accepts in 8 cycles; `vec_valid` rises after the 8th accept; lanes 0..7 = 1..8; lanes 8,9 = 0; `sat_cnt=0`.
- Shift, rounding and ReLU: `shift_amt=2`, results `1000` and `-7`, then `relu_en=1` with `-50`. Required lanes: `250`, `-2`, `0`; `sat_cnt=0`.
- Saturation: `shift_amt=0`, results `100000`, `-100000`, `32767`, `(2^35)-1`, then four 0s. Required lanes: `32767`, `-32768`, `32767`, `32767`; `sat_cnt=3`.
- Backpressure: fill 8 lanes, hold a 9th sample `in_valid=1` with `in_data=55` for 5 cycles, then pulse `vec_ack`. Required: `in_ready=0` and `vec_bus` unchanged during the stall; after ack, 55 is accepted into lane 0 the next cycle and `count=1`.
- Flush and reset mid-layer: accept 3 samples, assert `flush` together with `in_valid`. Required: the sample is dropped, `count=0`, `vec_bus=0`. Repeat with `rst_n=0` after 5 samples; required: same result.
- Chained layers: three layers of random `mac_engine`-style results with ack between them. Required: each `vec_bus` matches the golden requantize model and `sat_cnt` matches the counted clamps.
